// File: rtl/ps2_key_queue.sv
// PS/2 set-2 byte parser with typematic-repeat suppression feeding a small event FIFO.
// Define KEYQ_BREAK_EN to also queue break events (brk=1); otherwise only makes are queued.
module ps2_key_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ps2_key_pressed,
  input  logic [7:0]                   ps2_out,
  input  logic                         clear,
  input  logic                         load_req,
  output logic                         load_valid,
  output logic [31:0]                  load_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExt    = 2'd1;
  localparam logic [1:0] StBrk    = 2'd2;
  localparam logic [1:0] StExtBrk = 2'd3;

`ifdef KEYQ_BREAK_EN
  localparam bit BreakEn = 1'b1;
`else
  localparam bit BreakEn = 1'b0;
`endif

  logic [1:0]      state_q, state_d;
  logic            held_v_q, held_v_d;
  logic            held_ext_q, held_ext_d;
  logic [7:0]      held_code_q, held_code_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q;
  logic            load_valid_q;
  logic [31:0]     load_data_q;
  logic [9:0]      mem [DEPTH];

  logic discard, ev_valid, ev_brk, ev_ext, held_match;
  logic push_req, push, pop;

  always_comb begin
    discard = (ps2_out == 8'h00) || (ps2_out == 8'hAA) || (ps2_out == 8'hE1) ||
              (ps2_out == 8'hFA) || (ps2_out == 8'hFE) || (ps2_out == 8'hFF);
    ev_valid = 1'b0;
    ev_brk   = 1'b0;
    ev_ext   = 1'b0;
    state_d  = state_q;
    if (ps2_key_pressed) begin
      if (discard) begin
        state_d = StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (ps2_out == 8'hE0)      state_d = StExt;
            else if (ps2_out == 8'hF0) state_d = StBrk;
            else                       ev_valid = 1'b1;
          end
          StExt: begin
            if (ps2_out == 8'hF0) begin
              state_d = StExtBrk;
            end else begin
              ev_valid = 1'b1;
              ev_ext   = 1'b1;
              state_d  = StIdle;
            end
          end
          StBrk: begin
            ev_valid = 1'b1;
            ev_brk   = 1'b1;
            state_d  = StIdle;
          end
          default: begin
            ev_valid = 1'b1;
            ev_brk   = 1'b1;
            ev_ext   = 1'b1;
            state_d  = StIdle;
          end
        endcase
      end
    end
  end

  always_comb begin
    held_match  = held_v_q && (held_ext_q == ev_ext) && (held_code_q == ps2_out);
    held_v_d    = held_v_q;
    held_ext_d  = held_ext_q;
    held_code_d = held_code_q;
    push_req    = 1'b0;
    if (ev_valid && !ev_brk && !held_match) begin
      // New key (not a typematic repeat) becomes the held key.
      push_req    = 1'b1;
      held_v_d    = 1'b1;
      held_ext_d  = ev_ext;
      held_code_d = ps2_out;
    end else if (ev_valid && ev_brk) begin
      push_req = BreakEn;
      if (held_match) held_v_d = 1'b0;
    end
  end

  always_comb begin
    pop  = load_req && (count_q != '0);
    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    push = push_req && ((count_q != DepthCnt) || pop);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr_q] <= {ev_brk, ev_ext, ps2_out};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      held_v_q     <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= 32'h0;
    end else if (clear) begin
      state_q      <= StIdle;
      held_v_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      held_v_q     <= held_v_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
      count_q      <= count_d;
      load_valid_q <= load_req;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && !push) overflow_q <= 1'b1;
      if (load_req) load_data_q <= pop ? {22'b0, mem[rd_ptr_q]} : 32'h0;
    end
  end

  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_queue.sv
// Directed self-checking bench for ps2_key_queue (DEPTH=8); expectations follow KEYQ_BREAK_EN.
module tb_ps2_key_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_key_pressed = 1'b0;
  logic [7:0]  ps2_out = 8'h00;
  logic        clear = 1'b0;
  logic        load_req = 1'b0;
  logic        load_valid;
  logic [31:0] load_data;
  logic [3:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  ps2_key_queue #(.DEPTH(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_out         (ps2_out),
    .clear           (clear),
    .load_req        (load_req),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .fifo_count      (fifo_count),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; outputs are sampled at the following negedge.
  task automatic cycle(input logic stb, input logic [7:0] b, input logic req, input logic clr);
    ps2_key_pressed = stb;
    ps2_out         = b;
    load_req        = req;
    clear           = clr;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    load_req        = 1'b0;
    clear           = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag, input logic [31:0] exp);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_val({tag, "_valid"}, {31'b0, load_valid}, 32'd1);
    check_val({tag, "_data"}, load_data, exp);
  endtask

  initial begin
    int exp_cnt;
    repeat (2) @(negedge clock);
    check_val("rst_valid", {31'b0, load_valid}, 32'd0);
    check_val("rst_data", load_data, 32'h0);
    check_val("rst_count", {28'b0, fifo_count}, 32'd0);
    check_val("rst_ovf", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single make, popped two cycles after the strobe.
    send(8'h1D);
    check_val("one_count", {28'b0, fifo_count}, 32'd1);
    @(negedge clock);
    pop("one_pop", 32'h01D);
    check_val("one_count_after", {28'b0, fifo_count}, 32'd0);
    @(negedge clock);
    check_val("one_valid_drop", {31'b0, load_valid}, 32'd0);

    // Typematic repeats dropped, re-press after release kept.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D); send(8'h1D);
`ifdef KEYQ_BREAK_EN
    exp_cnt = 3;
`else
    exp_cnt = 2;
`endif
    check_val("rep_count", {28'b0, fifo_count}, exp_cnt);
    pop("rep_pop0", 32'h01D);
`ifdef KEYQ_BREAK_EN
    pop("rep_pop1", 32'h21D);
`endif
    pop("rep_pop2", 32'h01D);

    // Extended make, then extended break.
    send(8'hE0); send(8'h75);
    pop("ext_make", 32'h175);
    send(8'hE0); send(8'hF0); send(8'h75);
`ifdef KEYQ_BREAK_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    check_val("ext_brk_count", {28'b0, fifo_count}, exp_cnt);
`ifdef KEYQ_BREAK_EN
    pop("ext_brk_pop", 32'h375);
`endif

    // Discarded byte aborts a pending break prefix.
    send(8'hF0); send(8'hAA); send(8'h1C);
    check_val("disc_count", {28'b0, fifo_count}, 32'd1);
    pop("disc_pop", 32'h01C);

    // Overflow: nine distinct makes into eight slots.
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    check_val("ovf_count", {28'b0, fifo_count}, 32'd8);
    check_val("ovf_flag", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) pop("drain", 32'h010 + 32'(i));
    pop("drain_empty", 32'h0);
    check_val("drain_count", {28'b0, fifo_count}, 32'd0);

    // Full FIFO with simultaneous push and pop.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_val("clr_ovf", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    check_val("full_count", {28'b0, fifo_count}, 32'd8);
    cycle(1'b1, 8'h28, 1'b1, 1'b0);
    check_val("full_pp_count", {28'b0, fifo_count}, 32'd8);
    check_val("full_pp_ovf", {31'b0, overflow}, 32'd0);
    check_val("full_pp_data", load_data, 32'h020);

    // Clear beats a same-cycle strobe and request.
    cycle(1'b1, 8'h29, 1'b1, 1'b1);
    check_val("clr_count", {28'b0, fifo_count}, 32'd0);
    check_val("clr_valid", {31'b0, load_valid}, 32'd0);
    pop("clr_empty", 32'h0);
    send(8'h28);
    check_val("clr_held", {28'b0, fifo_count}, 32'd1);
    pop("clr_held_pop", 32'h028);

    // Push and pop on empty FIFO: pop must not see the entry being pushed.
    cycle(1'b1, 8'h40, 1'b1, 1'b0);
    check_val("empty_pp_valid", {31'b0, load_valid}, 32'd1);
    check_val("empty_pp_data", load_data, 32'h0);
    check_val("empty_pp_count", {28'b0, fifo_count}, 32'd1);
    pop("empty_pp_pop", 32'h040);

    // Mid-operation reset with entries queued and parser in BRK.
    send(8'h30); send(8'h31); send(8'h32); send(8'hF0);
    check_val("pre_rst_count", {28'b0, fifo_count}, 32'd3);
    reset = 1'b1;
    #2;
    check_val("async_rst_count", {28'b0, fifo_count}, 32'd0);
    check_val("async_rst_data", load_data, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send(8'h1C);
    check_val("post_rst_count", {28'b0, fifo_count}, 32'd1);
    pop("post_rst_pop", 32'h01C);
    pop("post_rst_empty", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
